csi_dphy_rx_seq: RTL and testbench

Controller that sequences the 2-lane D-PHY RX and CSI-2 capture datapath through each high-speed burst. It watches the lane-0 LP line state and drives the PHY's termination enable and HS enable, plus a word-aligner restart pulse. It closes the burst on packet completion from the capture logic, on a return to LP stop state, or on timeout. It replaces ad-hoc hs_en/term_en glue and adds SoT-error and timeout reporting.

---
 rtl/csi_dphy_rx_seq.sv | 157 +++++++++++++++
 tb/tb_csi_dphy_rx_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/csi_dphy_rx_seq.sv
// csi_dphy_rx_seq: sequences the 2-lane D-PHY RX / CSI-2 capture path through
// each HS burst. Watches lane-0 LP state, drives term_en / hs_en, pulses
// align_rst on SoT, and reports sync and RX timeouts.
// Optional LP glitch filter: define CSI_LP_GLITCH_FILTER_EN.
module csi_dphy_rx_seq #(
    parameter int SETTLE_CYC = 4,
    parameter int SYNC_TMO   = 32,
    parameter int RX_TMO     = 4096,
    parameter int GLITCH_CYC = 3
) (
    input  logic       sclk_l,
    input  logic       rstn,
    input  logic [1:0] lp_data0,
    input  logic       sync_found,
    input  logic       burst_done,
    output logic       term_en,
    output logic       hs_en,
    output logic       align_rst,
    output logic       hs_active,
    output logic       err_sot,
    output logic       err_tmo,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_STOP = 3'd0,
        ST_REQ  = 3'd1,
        ST_PREP = 3'd2,
        ST_SYNC = 3'd3,
        ST_RX   = 3'd4,
        ST_EXIT = 3'd5
    } st_t;

    // Elaboration-time parameter range checks
    if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
        $error("SETTLE_CYC out of range");
    end
    if (SYNC_TMO < 1 || SYNC_TMO > 65535) begin : g_bad_sync
        $error("SYNC_TMO out of range");
    end
    if (RX_TMO < 1 || RX_TMO > 65535) begin : g_bad_rx
        $error("RX_TMO out of range");
    end
    if (GLITCH_CYC < 2 || GLITCH_CYC > 15) begin : g_bad_glitch
        $error("GLITCH_CYC out of range");
    end

    logic [1:0] lp_m, lp_sy, lp_s;

    // 2-flop synchronizer; idles at LP-11 out of reset
    always_ff @(posedge sclk_l or negedge rstn) begin
        if (!rstn) begin
            lp_m  <= 2'b11;
            lp_sy <= 2'b11;
        end else begin
            lp_m  <= lp_data0;
            lp_sy <= lp_m;
        end
    end

`ifdef CSI_LP_GLITCH_FILTER_EN
    logic [1:0] lp_prev, lp_hold;
    logic [3:0] run, len_now;

    // Length of the current run of identical synchronized samples, this cycle included
    always_comb begin
        len_now = 4'd1;
        if (lp_sy == lp_prev)
            len_now = (run == 4'hF) ? run : run + 4'd1;
    end

    // Pass the new value once it has been stable long enough, else hold
    assign lp_s = (len_now >= 4'(GLITCH_CYC)) ? lp_sy : lp_hold;

    // Run-length history and held filter output
    always_ff @(posedge sclk_l or negedge rstn) begin
        if (!rstn) begin
            lp_prev <= 2'b11;
            lp_hold <= 2'b11;
            run     <= 4'd0;
        end else begin
            lp_prev <= lp_sy;
            lp_hold <= lp_s;
            run     <= len_now;
        end
    end
`else
    assign lp_s = lp_sy;
`endif

    st_t         cur, nxt;
    logic [15:0] cnt, cnt_inc;
    logic        sot_nxt, tmo_nxt;

    // Saturating increment: the shared timer never wraps
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Next-state and error-pulse decode
    always_comb begin
        nxt     = cur;
        sot_nxt = 1'b0;
        tmo_nxt = 1'b0;
        case (cur)
            ST_STOP: if (lp_s == 2'b01) nxt = ST_REQ;
            ST_REQ: begin
                if (lp_s == 2'b00)      nxt = ST_PREP;
                else if (lp_s[1])       nxt = ST_STOP;
            end
            ST_PREP: begin
                if (lp_s != 2'b00)                     nxt = ST_STOP;
                else if (cnt_inc >= 16'(SETTLE_CYC))   nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (sync_found) nxt = ST_RX;
                else if (cnt_inc >= 16'(SYNC_TMO)) begin
                    nxt     = ST_EXIT;
                    sot_nxt = 1'b1;
                end
            end
            ST_RX: begin
                if (burst_done || lp_s == 2'b11) nxt = ST_EXIT;
                else if (cnt_inc >= 16'(RX_TMO)) begin
                    nxt     = ST_EXIT;
                    tmo_nxt = 1'b1;
                end
            end
            ST_EXIT: if (lp_s == 2'b11) nxt = ST_STOP;
            default: nxt = ST_STOP;
        endcase
    end

    // State, timer and registered Moore outputs all move on the same edge
    always_ff @(posedge sclk_l or negedge rstn) begin
        if (!rstn) begin
            cur       <= ST_STOP;
            cnt       <= 16'd0;
            term_en   <= 1'b0;
            hs_en     <= 1'b0;
            align_rst <= 1'b0;
            hs_active <= 1'b0;
            err_sot   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= (nxt != cur) ? 16'd0 : cnt_inc;
            term_en   <= (nxt == ST_PREP) || (nxt == ST_SYNC) || (nxt == ST_RX);
            hs_en     <= (nxt == ST_SYNC) || (nxt == ST_RX);
            align_rst <= (nxt == ST_SYNC) && (cur != ST_SYNC);
            hs_active <= (nxt == ST_RX);
            err_sot   <= sot_nxt;
            err_tmo   <= tmo_nxt;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_csi_dphy_rx_seq.sv
// tb_csi_dphy_rx_seq: directed vector table plus hand-written timeout,
// reset and (when CSI_LP_GLITCH_FILTER_EN is defined) glitch-filter sequences.
module tb_csi_dphy_rx_seq;

`ifdef CSI_LP_GLITCH_FILTER_EN
    localparam int EXT = 2;
`else
    localparam int EXT = 0;
`endif

    logic       sclk_l = 1'b0;
    logic       rstn;
    logic [1:0] lp_data0;
    logic       sync_found, burst_done;
    logic       term_en, hs_en, align_rst, hs_active, err_sot, err_tmo;
    logic [2:0] state;

    int ncmp = 0;
    int nfail = 0;

    csi_dphy_rx_seq #(.SETTLE_CYC(4), .SYNC_TMO(32), .RX_TMO(4096), .GLITCH_CYC(3)) dut (
        .sclk_l(sclk_l), .rstn(rstn), .lp_data0(lp_data0),
        .sync_found(sync_found), .burst_done(burst_done),
        .term_en(term_en), .hs_en(hs_en), .align_rst(align_rst),
        .hs_active(hs_active), .err_sot(err_sot), .err_tmo(err_tmo), .state(state)
    );

    always #5 sclk_l = ~sclk_l;

    typedef struct {
        logic [1:0] lp;
        logic       sf, bd;
        logic [2:0] st;
        logic       term, hs, al, act;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] lp, logic sf, logic bd, logic [2:0] st,
                                logic term, logic hs, logic al, logic act);
        vec_t v;
        v.lp = lp; v.sf = sf; v.bd = bd; v.st = st;
        v.term = term; v.hs = hs; v.al = al; v.act = act;
        return v;
    endfunction

    // {state, term_en, hs_en, align_rst, hs_active, err_sot, err_tmo}
    function automatic logic [8:0] obs();
        return {state, term_en, hs_en, align_rst, hs_active, err_sot, err_tmo};
    endfunction

    task automatic tick();
        @(posedge sclk_l);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic to_sync();
        lp_data0 = 2'b01;
        repeat (3 + EXT) tick();
        lp_data0 = 2'b00;
        repeat (7 + EXT) tick();
        chk("sync_entry", 32'(obs()), 32'({3'd3, 6'b111000}));
    endtask

    task automatic back_to_stop(input string nm);
        lp_data0 = 2'b11;
        repeat (3 + EXT) tick();
        chk(nm, 32'(obs()), 32'd0);
    endtask

    initial begin
        int bad;
        rstn = 1'b0; lp_data0 = 2'b11; sync_found = 1'b0; burst_done = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'(obs()), 32'd0);
        rstn = 1'b1;
        tick();
        chk("post_reset", 32'(obs()), 32'd0);

`ifndef CSI_LP_GLITCH_FILTER_EN
        // pulses outside SYNC/RX are ignored
        tbl.push_back(mk(2'b11, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));
        // normal burst
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 3, 1, 1, 1, 0));
        tbl.push_back(mk(2'b00, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 4, 1, 1, 0, 1));
        tbl.push_back(mk(2'b00, 0, 0, 4, 1, 1, 0, 1));
        tbl.push_back(mk(2'b00, 0, 1, 5, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));
        // aborted request
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));
        // PREP abandoned before settle completes
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            lp_data0 = tbl[i].lp; sync_found = tbl[i].sf; burst_done = tbl[i].bd;
            tick();
            chk($sformatf("vec[%0d]", i), 32'(obs()),
                32'({tbl[i].st, tbl[i].term, tbl[i].hs, tbl[i].al, tbl[i].act, 2'b00}));
        end
        sync_found = 1'b0; burst_done = 1'b0;
`else
        // 2-cycle glitch in STOP is rejected
        lp_data0 = 2'b01;
        repeat (2) tick();
        lp_data0 = 2'b11;
        bad = 0;
        repeat (6) begin tick(); if (state != 3'd0) bad++; end
        chk("glitch_reject", 32'(bad), 32'd0);
        // held 01 reaches REQ two edges later than unfiltered
        lp_data0 = 2'b01;
        repeat (4) tick();
        chk("filt_pre", 32'(state), 32'd0);
        tick();
        chk("filt_req", 32'(state), 32'd1);
        back_to_stop("filt_stop");
`endif

        // SoT sync timeout
        to_sync();
        bad = 0;
        repeat (31) begin tick(); if (err_sot || state != 3'd3) bad++; end
        chk("sot_early", 32'(bad), 32'd0);
        tick();
        chk("sot_pulse", 32'(obs()), 32'({3'd5, 6'b000010}));
        tick();
        chk("sot_clear", 32'(obs()), 32'({3'd5, 6'b000000}));
        back_to_stop("sot_stop");

        // RX timeout
        to_sync();
        sync_found = 1'b1; tick(); sync_found = 1'b0;
        chk("rx_entry", 32'(obs()), 32'({3'd4, 6'b110100}));
        bad = 0;
        repeat (4095) begin tick(); if (err_tmo || state != 3'd4) bad++; end
        chk("tmo_early", 32'(bad), 32'd0);
        tick();
        chk("tmo_pulse", 32'(obs()), 32'({3'd5, 6'b000001}));
        tick();
        chk("tmo_clear", 32'(obs()), 32'({3'd5, 6'b000000}));
        back_to_stop("tmo_stop");

        // burst_done on the timeout cycle wins
        to_sync();
        sync_found = 1'b1; tick(); sync_found = 1'b0;
        repeat (4095) tick();
        burst_done = 1'b1; tick(); burst_done = 1'b0;
        chk("bd_vs_tmo", 32'(obs()), 32'({3'd5, 6'b000000}));
        tick();
        chk("bd_vs_tmo_after", 32'(obs()), 32'({3'd5, 6'b000000}));
        back_to_stop("bd_stop");

        // LP-11 during RX closes the burst
        to_sync();
        sync_found = 1'b1; tick(); sync_found = 1'b0;
        lp_data0 = 2'b11;
        repeat (2 + EXT) tick();
        chk("lp11_hold", 32'(state), 32'd4);
        tick();
        chk("lp11_exit", 32'(obs()), 32'({3'd5, 6'b000000}));
        tick();
        chk("lp11_stop", 32'(state), 32'd0);

        // async reset while align_rst is mid-pulse
        to_sync();
        rstn = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        tick();
        lp_data0 = 2'b11;
        rstn = 1'b1;
        tick();
        chk("rst_release", 32'(obs()), 32'd0);
        to_sync();
        sync_found = 1'b1; tick(); sync_found = 1'b0;
        chk("rst_rx", 32'(obs()), 32'({3'd4, 6'b110100}));
        burst_done = 1'b1; tick(); burst_done = 1'b0;
        chk("rst_done", 32'(obs()), 32'({3'd5, 6'b000000}));
        back_to_stop("rst_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end

endmodule
